// File: rtl/stim_event_player.sv
// stim_event_player: replays a preloaded table of timed events into the
// input_i/new_input_i ports of a monitor, with masks, stall, loop and stop.
//
// Ports:
//   clk, rst (async, active low), en (clock enable)
//   cfg_we/cfg_addr/cfg_delay/cfg_mask/cfg_data : table write port
//   cfg_len, loop_mode : playback length and wrap mode, sampled at start
//   start, stop        : playback control pulses
//   stall              : monitor not ready, defers a due emission
//   out_data, out_new  : packed values and per-channel strobes
//   busy, done, evt_idx: playback status
module stim_event_player #(
  parameter int CHANNELS = 2,
  parameter int DATA_W   = 64,
  parameter int DEPTH    = 16,
  parameter int DELAY_W  = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int PW = CHANNELS * DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cfg_we,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [DELAY_W-1:0]  cfg_delay,
  input  logic [CHANNELS-1:0] cfg_mask,
  input  logic [PW-1:0]       cfg_data,
  input  logic [AW:0]         cfg_len,
  input  logic                loop_mode,
  input  logic                start,
  input  logic                stop,
  input  logic                stall,
  output logic [PW-1:0]       out_data,
  output logic [CHANNELS-1:0] out_new,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       evt_idx
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [DELAY_W-1:0]  tbl_delay [DEPTH];
  logic [CHANNELS-1:0] tbl_mask  [DEPTH];
  logic [PW-1:0]       tbl_data  [DEPTH];

  logic [DELAY_W-1:0]  cnt, cnt_n;
  logic [AW:0]         len, len_n;
  logic                loop_q, loop_n;
  logic [AW-1:0]       idx_n;
  logic [PW-1:0]       data_n;
  logic [CHANNELS-1:0] new_n;
  logic                busy_n, done_n;

  logic                last;
  logic [AW-1:0]       nidx;
  logic [AW-1:0]       rd_idx;
  logic [DELAY_W-1:0]  rd_delay;
  logic [CHANNELS-1:0] rd_mask;
  logic [PW-1:0]       rd_data;
  logic [PW-1:0]       rd_masked;

  always_ff @(posedge clk) begin
    if (en && cfg_we && !busy) begin
      tbl_delay[cfg_addr] <= cfg_delay;
      tbl_mask[cfg_addr]  <= cfg_mask;
      tbl_data[cfg_addr]  <= cfg_data;
    end
  end

  assign last = ({1'b0, evt_idx} + (AW+1)'(1)) >= len;
  assign nidx = last ? '0 : evt_idx + AW'(1);

  // Single read port: WAIT looks at the pending entry, EMIT looks
  // ahead to the entry that follows it.
  always_comb begin
    unique case (state)
      WAIT:    rd_idx = evt_idx;
      EMIT:    rd_idx = nidx;
      default: rd_idx = '0;
    endcase
  end

  assign rd_delay = tbl_delay[rd_idx];
  assign rd_mask  = tbl_mask[rd_idx];
  assign rd_data  = tbl_data[rd_idx];

  always_comb begin
    rd_masked = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (rd_mask[c]) begin
        rd_masked[c*DATA_W +: DATA_W] =
          rd_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len;
    loop_n  = loop_q;
    idx_n   = evt_idx;
    data_n  = '0;
    new_n   = '0;
    busy_n  = busy;
    done_n  = done;
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (cfg_len == '0) begin
              state_n = DONE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = WAIT;
              len_n   = cfg_len;
              loop_n  = loop_mode;
              idx_n   = '0;
              cnt_n   = rd_delay;
              busy_n  = 1'b1;
              done_n  = 1'b0;
            end
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt_n = cnt - DELAY_W'(1);
          end else if (!stall) begin
            state_n = EMIT;
            data_n  = rd_masked;
            new_n   = rd_mask;
          end
        end
        EMIT: begin
          if (last && !loop_q) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = nidx;
            // The emit cycle already counts as the first cycle of
            // the next delay, so zero delay can emit back to back.
            if (rd_delay == '0 && !stall) begin
              state_n = EMIT;
              data_n  = rd_masked;
              new_n   = rd_mask;
            end else begin
              state_n = WAIT;
              cnt_n   = (rd_delay == '0) ? '0
                      : rd_delay - DELAY_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      len      <= '0;
      loop_q   <= 1'b0;
      evt_idx  <= '0;
      out_data <= '0;
      out_new  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (en) begin
      state    <= state_n;
      cnt      <= cnt_n;
      len      <= len_n;
      loop_q   <= loop_n;
      evt_idx  <= idx_n;
      out_data <= data_n;
      out_new  <= new_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_stim_event_player.sv
// tb_stim_event_player: directed and randomized playback checked against
// an event-time model computed from delays, stalls, loop and stop rules.
module tb_stim_event_player;

  localparam int CH   = 2;
  localparam int DW   = 64;
  localparam int DP   = 16;
  localparam int DLW  = 16;
  localparam int AW   = 4;
  localparam int PW   = CH * DW;
  localparam int MAXT = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DLW-1:0] cfg_delay = '0;
  logic [CH-1:0] cfg_mask = '0;
  logic [PW-1:0] cfg_data = '0;
  logic [AW:0]   cfg_len = '0;
  logic          loop_mode = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          stall = 1'b0;
  logic [PW-1:0] out_data;
  logic [CH-1:0] out_new;
  logic          busy;
  logic          done;
  logic [AW-1:0] evt_idx;

  always #5 clk = ~clk;

  stim_event_player #(
    .CHANNELS(CH),
    .DATA_W(DW),
    .DEPTH(DP),
    .DELAY_W(DLW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_delay(cfg_delay),
    .cfg_mask(cfg_mask),
    .cfg_data(cfg_data),
    .cfg_len(cfg_len),
    .loop_mode(loop_mode),
    .start(start),
    .stop(stop),
    .stall(stall),
    .out_data(out_data),
    .out_new(out_new),
    .busy(busy),
    .done(done),
    .evt_idx(evt_idx)
  );

  int errs = 0;
  int checks = 0;

  int            m_delay [DP];
  logic [CH-1:0] m_mask  [DP];
  logic [PW-1:0] m_data  [DP];
  bit            m_fin;

  bit            stall_k [MAXT];
  logic [CH-1:0] x_new   [MAXT];
  logic [PW-1:0] x_data  [MAXT];
  bit            x_busy  [MAXT];
  bit            x_done  [MAXT];
  int            x_idx   [MAXT];

  task automatic check(input string tag,
                       input logic [PW-1:0] got,
                       input logic [PW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] masked(input logic [PW-1:0] v,
                                           input logic [CH-1:0] m);
    logic [PW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++)
      if (m[c]) r[c*DW +: DW] = v[c*DW +: DW];
    return r;
  endfunction

  task automatic wr(input int a, input int d,
                    input logic [CH-1:0] m,
                    input logic [PW-1:0] v);
    en = 1'b1;
    cfg_we = 1'b1;
    cfg_addr = AW'(a);
    cfg_delay = DLW'(d);
    cfg_mask = m;
    cfg_data = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_delay[a] = d;
    m_mask[a] = m;
    m_data[a] = v;
  endtask

  task automatic clr_stall();
    for (int i = 0; i < MAXT; i++) stall_k[i] = 1'b0;
  endtask

  // Expected trajectory, indexed by enabled clock edges since start.
  task automatic build_model(input int len, input bit lp,
                             input int stop_at, input int win);
    int t, k, last_t, end_b;
    bit fin, cut;
    for (int i = 0; i <= win; i++) begin
      x_new[i] = '0;
      x_data[i] = '0;
      x_idx[i] = -1;
    end
    fin = 1'b0;
    last_t = 0;
    k = 0;
    if (len == 0) begin
      fin = 1'b1;
    end else begin
      t = 2 + m_delay[0];
      while (1) begin
        while (t <= win && stall_k[t-1]) t++;
        if (t > win) break;
        if (stop_at >= 0 && t > stop_at) break;
        x_new[t] = m_mask[k];
        x_data[t] = masked(m_data[k], m_mask[k]);
        x_idx[t] = k;
        last_t = t;
        if (k == len - 1) begin
          if (!lp) begin
            fin = 1'b1;
            break;
          end
          k = 0;
        end else begin
          k++;
        end
        t = t + 1 + m_delay[k];
      end
    end
    if (fin) end_b = last_t;
    else if (stop_at >= 0) end_b = stop_at;
    else end_b = win;
    for (int i = 1; i <= win; i++) begin
      cut = (stop_at >= 0) && (i > stop_at);
      x_busy[i] = (i <= end_b);
      x_done[i] = fin && (i > last_t) && !cut;
    end
    m_fin = fin;
  endtask

  task automatic play(input int len, input bit lp,
                      input int stop_at, input int wr_at,
                      input int win, input int off_pct,
                      input string nm);
    int tk, cy;
    bit en_cur;
    build_model(len, lp, stop_at, win);
    en = 1'b1;
    start = 1'b1;
    cfg_len = (AW+1)'(len);
    loop_mode = lp;
    stall = stall_k[0];
    stop = 1'b0;
    tk = 0;
    cy = 0;
    en_cur = 1'b1;
    while (tk < win) begin
      @(posedge clk);
      tk += int'(en_cur);
      cy++;
      #1;
      start = 1'b0;
      cfg_we = 1'b0;
      en_cur = 1'b1;
      if (off_pct > 0 && cy < 2 * win &&
          $urandom_range(99) < off_pct)
        en_cur = 1'b0;
      en = en_cur;
      stall = en_cur ? stall_k[tk] : ($urandom_range(1) == 1);
      stop = en_cur && (tk == stop_at);
      if (en_cur && tk == wr_at) begin
        cfg_we = 1'b1;
        cfg_addr = '0;
        cfg_delay = DLW'($urandom);
        cfg_mask = ~m_mask[0];
        cfg_data = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      check($sformatf("%s new t%0d", nm, tk),
            PW'(out_new), PW'(x_new[tk]));
      check($sformatf("%s data t%0d", nm, tk),
            out_data, x_data[tk]);
      check($sformatf("%s busy t%0d", nm, tk),
            PW'(busy), PW'(x_busy[tk]));
      check($sformatf("%s done t%0d", nm, tk),
            PW'(done), PW'(x_done[tk]));
      if (x_idx[tk] >= 0)
        check($sformatf("%s idx t%0d", nm, tk),
              PW'(evt_idx), PW'(x_idx[tk]));
    end
    @(posedge clk); #1;
    en = 1'b1;
    stop = 1'b0;
    stall = 1'b0;
    cfg_we = 1'b0;
    if (!m_fin) begin
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
    end
  endtask

  task automatic rst_checks(input string nm);
    check({nm, " new"}, PW'(out_new), '0);
    check({nm, " data"}, out_data, '0);
    check({nm, " busy"}, PW'(busy), '0);
    check({nm, " done"}, PW'(done), '0);
    check({nm, " idx"}, PW'(evt_idx), '0);
  endtask

  initial begin
    #300_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_stall();
    repeat (3) @(posedge clk);
    #1;
    rst_checks("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // basic playback, long delays
    for (int e = 0; e < 3; e++)
      wr(e, 999, 2'b11, {64'(e + 1), 64'(e + 1)});
    play(3, 1'b0, -1, -1, 3010, 0, "basic");

    // masks and back-to-back emissions
    wr(0, 0, 2'b01, {64'd9, 64'd5});
    wr(1, 0, 2'b10, {64'd7, 64'd6});
    play(2, 1'b0, -1, -1, 8, 0, "b2b");

    // stall defers only the due event
    wr(0, 4, 2'b11, {64'hA, 64'hB});
    wr(1, 2, 2'b01, {64'hC, 64'hFFFF_FFFF_FFFF_FFFF});
    for (int i = 5; i <= 7; i++) stall_k[i] = 1'b1;
    play(2, 1'b0, -1, -1, 16, 0, "stall");
    clr_stall();

    // loop with stop; a write while busy must be dropped
    wr(0, 3, 2'b10, {64'h8000_0000_0000_0001, 64'd3});
    wr(1, 3, 2'b01, {64'd4, 64'h7FFF_FFFF_FFFF_FFFF});
    play(2, 1'b1, 15, 2, 20, 0, "loop");
    play(2, 1'b0, -1, -1, 12, 0, "guard");

    // zero length start
    play(0, 1'b0, -1, -1, 5, 0, "len0");

    // asynchronous reset in EMIT, then in WAIT
    wr(0, 3, 2'b11, {64'h1234, 64'h5678});
    wr(1, 50, 2'b01, {64'h9, 64'hABCD});
    en = 1'b1;
    cfg_len = 5'd2;
    loop_mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre-rst new", PW'(out_new), PW'(2'b11));
    #2 rst = 1'b0;
    #1 rst_checks("rst emit");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    @(negedge clk);
    check("pre-rst idx", PW'(evt_idx), PW'(1));
    check("pre-rst busy", PW'(busy), PW'(1));
    #2 rst = 1'b0;
    #1 rst_checks("rst wait");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    play(2, 1'b0, -1, -1, 70, 0, "keep");

    // randomized tables, stalls, enables, loop and stop
    for (int it = 0; it < 12; it++) begin
      int len, sa;
      bit lp;
      for (int e = 0; e < DP; e++)
        wr(e, int'($urandom_range(6)), CH'($urandom),
           {$urandom, $urandom, $urandom, $urandom});
      for (int i = 0; i < MAXT; i++)
        stall_k[i] = ($urandom_range(3) == 0);
      len = int'($urandom_range(DP));
      lp = ($urandom_range(1) == 1);
      sa = ($urandom_range(3) == 0) ?
           int'($urandom_range(119, 1)) : -1;
      play(len, lp, sa, -1, 120, 10, $sformatf("rnd%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
